// File: rtl/bpsk_nco.sv
// bpsk_nco: phase-accumulator NCO with a quarter-wave sine LUT and BPSK carrier inversion
// applied on carrier-cycle-aligned symbol boundaries. Define COS_OUT_EN to add quadrature cos_out.
module bpsk_nco #(
    parameter int                 OUT_W       = 16,
    parameter int                 PHASE_W     = 32,
    parameter int                 LUT_AW      = 8,
    parameter logic [PHASE_W-1:0] DEFAULT_INC = 32'h0400_0000,
    parameter int                 SYM_CYCLES  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [PHASE_W-1:0]      freq_word,
    input  logic                    freq_load,
    input  logic                    bit_in,
    input  logic                    bit_valid,
    output logic                    bit_ready,
    output logic signed [OUT_W-1:0] sine_out,
`ifdef COS_OUT_EN
    output logic signed [OUT_W-1:0] cos_out,
`endif
    output logic                    sine_rdy,
    output logic                    underrun
);

    localparam int LUT_SIZE = 1 << LUT_AW;
    localparam int PIDX_W   = LUT_AW + 2;
    localparam int MAG_W    = OUT_W - 1;
    localparam int CNT_W    = (SYM_CYCLES > 1) ? $clog2(SYM_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SYM_LAST = CNT_W'(SYM_CYCLES - 1);

    // Elaboration-time sine: Taylor series is exact to double precision over [0, pi/2].
    function automatic int lut_value(input int k);
        real x;
        real term;
        real s;
        x    = 3.14159265358979323846 / 2.0 * (real'(k) + 0.5) / real'(LUT_SIZE);
        term = x;
        s    = x;
        for (int n = 1; n < 12; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            s    = s + term;
        end
        return $rtoi(s * real'((1 << (OUT_W - 1)) - 1) + 0.5);
    endfunction

    function automatic logic [LUT_AW-1:0] fold_addr(input logic [PIDX_W-1:0] p, input logic q0);
        return q0 ? ~p[LUT_AW-1:0] : p[LUT_AW-1:0];
    endfunction

    // The half-step LUT never holds the most negative code, so negation cannot overflow.
    function automatic logic signed [OUT_W-1:0] apply_sign(input logic [MAG_W-1:0] mag,
                                                            input logic neg);
        logic signed [OUT_W-1:0] s;
        s = signed'({1'b0, mag});
        return neg ? -s : s;
    endfunction

    logic [MAG_W-1:0] lut [LUT_SIZE];
    for (genvar k = 0; k < LUT_SIZE; k++) begin : g_lut
        localparam int VAL = lut_value(k);
        assign lut[k] = VAL[MAG_W-1:0];
    end

    logic [PHASE_W-1:0]      acc_q, acc_d, inc_q, inc_d;
    logic [PHASE_W:0]        acc_sum;
    logic [CNT_W-1:0]        sym_cnt_q, sym_cnt_d;
    logic                    cur_bit_q, cur_bit_d;
    logic                    pend_full_q, pend_full_d, pend_bit_q, pend_bit_d;
    logic                    underrun_q, underrun_d;
    logic                    wrap, boundary, accept;
    logic [PIDX_W-1:0]       phase_idx;
    logic [1:0]              quad_sin;
    logic                    vld_p0_q, vld_p0_d, vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
    logic [MAG_W-1:0]        mag_p1_q, mag_p1_d;
    logic                    neg_p1_q, neg_p1_d;
    logic signed [OUT_W-1:0] sine_p2_q, sine_p2_d;
`ifdef COS_OUT_EN
    logic [1:0]              quad_cos;
    logic [MAG_W-1:0]        mag_cos_p1_q, mag_cos_p1_d;
    logic                    neg_cos_p1_q, neg_cos_p1_d;
    logic signed [OUT_W-1:0] cos_p2_q, cos_p2_d;
`endif

    always_comb begin
        // S0: accumulator, frequency word, symbol timing and bit handshake
        acc_sum  = {1'b0, acc_q} + {1'b0, inc_q};
        wrap     = en & acc_sum[PHASE_W];
        boundary = wrap & (sym_cnt_q == SYM_LAST);
        accept   = bit_valid & ~pend_full_q;

        inc_d = freq_load ? freq_word : inc_q;
        acc_d = en ? acc_sum[PHASE_W-1:0] : acc_q;

        sym_cnt_d = sym_cnt_q;
        if (boundary) begin
            sym_cnt_d = '0;
        end else if (wrap) begin
            sym_cnt_d = sym_cnt_q + CNT_W'(1);
        end

        cur_bit_d   = cur_bit_q;
        pend_full_d = pend_full_q;
        pend_bit_d  = pend_bit_q;
        if (boundary && pend_full_q) begin
            cur_bit_d   = pend_bit_q;
            pend_full_d = 1'b0;
        end
        // A bit accepted on an empty-slot boundary waits for the next symbol.
        if (accept) begin
            pend_full_d = 1'b1;
            pend_bit_d  = bit_in;
        end
        underrun_d = boundary & ~pend_full_q;

        // S1: quadrant fold and LUT read; the BPSK flip rides on the quadrant MSB
        phase_idx = acc_q[PHASE_W-1 -: PIDX_W];
        quad_sin  = phase_idx[PIDX_W-1 -: 2] ^ {cur_bit_q, 1'b0};
        mag_p1_d  = en ? lut[fold_addr(phase_idx, quad_sin[0])] : mag_p1_q;
        neg_p1_d  = en ? quad_sin[1] : neg_p1_q;
`ifdef COS_OUT_EN
        quad_cos     = (phase_idx[PIDX_W-1 -: 2] + 2'd1) ^ {cur_bit_q, 1'b0};
        mag_cos_p1_d = en ? lut[fold_addr(phase_idx, quad_cos[0])] : mag_cos_p1_q;
        neg_cos_p1_d = en ? quad_cos[1] : neg_cos_p1_q;
`endif

        // S2: sign restore
        sine_p2_d = en ? apply_sign(mag_p1_q, neg_p1_q) : sine_p2_q;
`ifdef COS_OUT_EN
        cos_p2_d  = en ? apply_sign(mag_cos_p1_q, neg_cos_p1_q) : cos_p2_q;
`endif

        vld_p0_d = en | vld_p0_q;
        vld_p1_d = en ? vld_p0_q : vld_p1_q;
        vld_p2_d = en ? vld_p1_q : vld_p2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q        <= '0;
            inc_q        <= DEFAULT_INC;
            sym_cnt_q    <= '0;
            cur_bit_q    <= 1'b0;
            pend_full_q  <= 1'b0;
            pend_bit_q   <= 1'b0;
            underrun_q   <= 1'b0;
            vld_p0_q     <= 1'b0;
            vld_p1_q     <= 1'b0;
            vld_p2_q     <= 1'b0;
            mag_p1_q     <= '0;
            neg_p1_q     <= 1'b0;
            sine_p2_q    <= '0;
`ifdef COS_OUT_EN
            mag_cos_p1_q <= '0;
            neg_cos_p1_q <= 1'b0;
            cos_p2_q     <= '0;
`endif
        end else begin
            acc_q        <= acc_d;
            inc_q        <= inc_d;
            sym_cnt_q    <= sym_cnt_d;
            cur_bit_q    <= cur_bit_d;
            pend_full_q  <= pend_full_d;
            pend_bit_q   <= pend_bit_d;
            underrun_q   <= underrun_d;
            vld_p0_q     <= vld_p0_d;
            vld_p1_q     <= vld_p1_d;
            vld_p2_q     <= vld_p2_d;
            mag_p1_q     <= mag_p1_d;
            neg_p1_q     <= neg_p1_d;
            sine_p2_q    <= sine_p2_d;
`ifdef COS_OUT_EN
            mag_cos_p1_q <= mag_cos_p1_d;
            neg_cos_p1_q <= neg_cos_p1_d;
            cos_p2_q     <= cos_p2_d;
`endif
        end
    end

    assign bit_ready = ~pend_full_q;
    assign sine_out  = sine_p2_q;
    assign sine_rdy  = vld_p2_q & en;
    assign underrun  = underrun_q;
`ifdef COS_OUT_EN
    assign cos_out   = cos_p2_q;
`endif

endmodule
